// File: rtl/rle_frame_sched.sv
// Descriptor FIFO and launch sequencer for a run-length-encoder core: queues frame
// descriptors, starts the core, collects results. Define RLE_SCHED_LATENCY_EN for latency measurement.
module rle_frame_sched #(
  parameter int DEPTH      = 4,
  parameter int GAP_CYCLES = 10
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        desc_valid,
  output logic        desc_ready,
  input  logic [31:0] desc_msg_addr,
  input  logic [31:0] desc_msg_size,
  input  logic [31:0] desc_rle_addr,
  output logic        rle_start,
  output logic [31:0] rle_message_addr,
  output logic [31:0] rle_message_size,
  output logic [31:0] rle_rle_addr,
  input  logic        rle_done,
  input  logic [31:0] rle_size,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_size,
  output logic [31:0] res_latency,
  output logic        busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int GW = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_RUN,
    S_POST,
    S_GAP
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [31:0]   r_fifo_maddr [DEPTH];
  logic [31:0]   r_fifo_msize [DEPTH];
  logic [31:0]   r_fifo_raddr [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_launch_cnt;
  logic [GW-1:0] r_gap_cnt;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [31:0]   w_head_size;

  assign w_full      = (r_count == CW'(DEPTH));
  assign w_empty     = (r_count == '0);
  assign desc_ready  = !w_full;
  assign w_push      = desc_valid && !w_full;
  assign w_pop       = (r_state == S_IDLE) && !w_empty;
  assign w_head_size = r_fifo_msize[r_rd_ptr];

  // Storage has no reset so it can map onto distributed/block RAM.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_maddr[r_wr_ptr] <= desc_msg_addr;
      r_fifo_msize[r_wr_ptr] <= desc_msg_size;
      r_fifo_raddr[r_wr_ptr] <= desc_rle_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    rle_start    = 1'b0;
    busy         = (r_state != S_IDLE) || !w_empty;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) w_state_next = (w_head_size == '0) ? S_POST : S_LAUNCH;
      end
      S_LAUNCH: begin
        rle_start = 1'b1;
        if (r_launch_cnt) w_state_next = S_RUN;
      end
      S_RUN: begin
        if (rle_done) w_state_next = S_POST;
      end
      S_POST: begin
        if (res_ready) w_state_next = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
      end
      S_GAP: begin
        if (r_gap_cnt == GW'(GAP_CYCLES - 1)) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Core-facing fields are loaded only on a pop, so they stay put for the whole frame.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      rle_message_addr <= '0;
      rle_message_size <= '0;
      rle_rle_addr     <= '0;
      res_valid        <= 1'b0;
      res_size         <= '0;
      r_launch_cnt     <= 1'b0;
      r_gap_cnt        <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            rle_message_addr <= r_fifo_maddr[r_rd_ptr];
            rle_message_size <= w_head_size;
            rle_rle_addr     <= r_fifo_raddr[r_rd_ptr];
            r_launch_cnt     <= 1'b0;
            if (w_head_size == '0) begin
              res_size  <= '0;
              res_valid <= 1'b1;
            end
          end
        end
        S_LAUNCH: begin
          r_launch_cnt <= 1'b1;
        end
        S_RUN: begin
          if (rle_done) begin
            res_size  <= rle_size;
            res_valid <= 1'b1;
          end
        end
        S_POST: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            r_gap_cnt <= '0;
          end
        end
        S_GAP: begin
          r_gap_cnt <= r_gap_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef RLE_SCHED_LATENCY_EN
  logic [31:0] r_lat;

  // Zero in the first start cycle, then counts until done is seen; sticks at all-ones.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      r_lat       <= '0;
      res_latency <= '0;
    end else begin
      if (w_pop) begin
        r_lat <= '0;
      end else if (((r_state == S_LAUNCH) || (r_state == S_RUN)) && (r_lat != 32'hFFFF_FFFF)) begin
        r_lat <= r_lat + 32'd1;
      end
      if (w_pop && (w_head_size == '0)) begin
        res_latency <= '0;
      end else if ((r_state == S_RUN) && rle_done) begin
        res_latency <= r_lat;
      end
    end
  end
`else
  assign res_latency = '0;
`endif

endmodule

// File: tb/tb_rle_frame_sched.sv
// Randomized self-checking bench for rle_frame_sched with a behavioural RLE core
// (done after a chosen delay, compressed size = 2 x message size).
module tb_rle_frame_sched;

  localparam int DEPTH = 4;
  localparam int GAP   = 10;
`ifdef RLE_SCHED_LATENCY_EN
  localparam bit LAT_EN = 1'b1;
`else
  localparam bit LAT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        desc_valid = 1'b0;
  logic        desc_ready;
  logic [31:0] desc_msg_addr = '0;
  logic [31:0] desc_msg_size = '0;
  logic [31:0] desc_rle_addr = '0;
  logic        rle_start;
  logic [31:0] rle_message_addr;
  logic [31:0] rle_message_size;
  logic [31:0] rle_rle_addr;
  logic        rle_done = 1'b0;
  logic [31:0] rle_size = '0;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [31:0] res_size;
  logic [31:0] res_latency;
  logic        busy;

  int total = 0;
  int bad = 0;

  rle_frame_sched #(.DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .nreset(nreset),
    .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_msg_addr(desc_msg_addr), .desc_msg_size(desc_msg_size), .desc_rle_addr(desc_rle_addr),
    .rle_start(rle_start), .rle_message_addr(rle_message_addr),
    .rle_message_size(rle_message_size), .rle_rle_addr(rle_rle_addr),
    .rle_done(rle_done), .rle_size(rle_size),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_size(res_size), .res_latency(res_latency), .busy(busy)
  );

  always #5 clk = ~clk;

  // Event log written only by the monitor/core process below.
  logic [31:0] st_maddr [64];
  logic [31:0] st_msize [64];
  logic [31:0] st_raddr [64];
  int          st_cyc [64];
  int          st_len [64];
  int          st_delay [64];
  int          n_starts = 0;
  logic [31:0] rs_size [64];
  logic [31:0] rs_lat [64];
  logic [31:0] rs_maddr [64];
  int          rs_cyc [64];
  int          n_res = 0;
  int          cyc = 0;

  bit          prev_start = 1'b0;
  bit          core_busy = 1'b0;
  bit          core_done = 1'b0;
  int          core_k = 0;
  int          core_delay = 0;
  logic [31:0] core_size = '0;
  int          fixed_delay = 0;
  bit          force_done = 1'b0;

  // Core model and monitor, sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (!nreset) begin
      core_busy  = 1'b0;
      core_done  = 1'b0;
      prev_start = 1'b0;
    end else begin
      if (core_busy) begin
        core_k++;
        if (core_k == core_delay) begin
          core_done = 1'b1;
          core_busy = 1'b0;
        end
      end
      if (rle_start && !prev_start && n_starts < 64) begin
        core_delay = (fixed_delay != 0) ? fixed_delay : int'($urandom_range(30, 2));
        st_maddr[n_starts] = rle_message_addr;
        st_msize[n_starts] = rle_message_size;
        st_raddr[n_starts] = rle_rle_addr;
        st_cyc[n_starts]   = cyc;
        st_len[n_starts]   = 1;
        st_delay[n_starts] = core_delay;
        n_starts++;
        core_k    = 0;
        core_busy = 1'b1;
        core_done = 1'b0;
        core_size = rle_message_size << 1;
      end else if (rle_start && prev_start && n_starts > 0) begin
        st_len[n_starts-1]++;
      end
      prev_start = rle_start;
      if (res_valid && res_ready && n_res < 64) begin
        rs_size[n_res]  = res_size;
        rs_lat[n_res]   = res_latency;
        rs_maddr[n_res] = rle_message_addr;
        rs_cyc[n_res]   = cyc;
        $display("result %0d: size=%0d latency=%0d cycle=%0d", n_res, res_size, res_latency, cyc);
        n_res++;
      end
    end
    rle_done = core_done | force_done;
    rle_size = core_size;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] s, input logic [31:0] r, output logic rdy);
    rdy = desc_ready;
    desc_valid = 1'b1;
    desc_msg_addr = a;
    desc_msg_size = s;
    desc_rle_addr = r;
    @(posedge clk);
    #1;
    desc_valid = 1'b0;
  endtask

  task automatic wait_res(input int target, input int budget, output bit ok);
    int k;
    k = 0;
    while (n_res < target && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    ok = (n_res >= target);
  endtask

  task automatic test_reset();
    nreset = 1'b0;
    tick(3);
    total++; if (desc_ready !== 1'b1) begin bad++; $display("FAIL reset_desc_ready got=%0h want=1", desc_ready); end
    total++; if (rle_start !== 1'b0) begin bad++; $display("FAIL reset_rle_start got=%0h want=0", rle_start); end
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL reset_res_valid got=%0h want=0", res_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0h want=0", busy); end
    total++; if (res_size !== 32'd0) begin bad++; $display("FAIL reset_res_size got=%0h want=0", res_size); end
    total++; if (res_latency !== 32'd0) begin bad++; $display("FAIL reset_res_latency got=%0h want=0", res_latency); end
    total++; if (rle_message_addr !== 32'd0) begin bad++; $display("FAIL reset_msg_addr got=%0h want=0", rle_message_addr); end
    nreset = 1'b1;
    tick(2);
  endtask

  task automatic test_single();
    int bs, br;
    bit ok;
    logic rdy;
    bs = n_starts; br = n_res;
    fixed_delay = 40;
    push(32'h0, 32'd39, 32'hC8, rdy);
    total++; if (rdy !== 1'b1) begin bad++; $display("FAIL single_ready got=%0h want=1", rdy); end
    wait_res(br + 1, 200, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL single_timeout got=%0d want=%0d results", n_res - br, 1); end
    if (ok) begin
      total++; if (n_starts - bs !== 1) begin bad++; $display("FAIL single_starts got=%0d want=1", n_starts - bs); end
      total++; if (st_len[bs] !== 2) begin bad++; $display("FAIL single_start_len got=%0d want=2", st_len[bs]); end
      total++; if (st_msize[bs] !== 32'd39 || st_raddr[bs] !== 32'hC8 || st_maddr[bs] !== 32'h0)
        begin bad++; $display("FAIL single_fields got=%0h/%0h/%0h want=0/27/c8", st_maddr[bs], st_msize[bs], st_raddr[bs]); end
      total++; if (rs_size[br] !== 32'd78) begin bad++; $display("FAIL single_res_size got=%0d want=78", rs_size[br]); end
      total++; if (rs_lat[br] !== (LAT_EN ? 32'd40 : 32'd0))
        begin bad++; $display("FAIL single_latency got=%0d want=%0d", rs_lat[br], LAT_EN ? 40 : 0); end
    end
    fixed_delay = 0;
    tick(GAP + 4);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle_busy got=%0h want=0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a[3], s[3], r[3];
    logic rdy[3];
    int bs, br;
    bit ok;
    bs = n_starts; br = n_res;
    for (int i = 0; i < 3; i++) begin
      a[i] = $urandom; r[i] = $urandom; s[i] = 32'($urandom_range(5000, 1));
    end
    for (int i = 0; i < 3; i++) push(a[i], s[i], r[i], rdy[i]);
    for (int i = 0; i < 3; i++) begin
      total++; if (rdy[i] !== 1'b1) begin bad++; $display("FAIL b2b_ready%0d got=%0h want=1", i, rdy[i]); end
    end
    wait_res(br + 3, 400, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL b2b_timeout got=%0d want=3 results", n_res - br); end
    if (ok) begin
      for (int i = 0; i < 3; i++) begin
        total++; if (st_maddr[bs+i] !== a[i] || st_msize[bs+i] !== s[i] || st_raddr[bs+i] !== r[i])
          begin bad++; $display("FAIL b2b_fields%0d got=%0h/%0h/%0h want=%0h/%0h/%0h", i, st_maddr[bs+i], st_msize[bs+i], st_raddr[bs+i], a[i], s[i], r[i]); end
        total++; if (st_len[bs+i] !== 2) begin bad++; $display("FAIL b2b_start_len%0d got=%0d want=2", i, st_len[bs+i]); end
        total++; if (rs_size[br+i] !== (s[i] << 1)) begin bad++; $display("FAIL b2b_size%0d got=%0d want=%0d", i, rs_size[br+i], s[i] << 1); end
        total++; if (rs_lat[br+i] !== (LAT_EN ? 32'(st_delay[bs+i]) : 32'd0))
          begin bad++; $display("FAIL b2b_latency%0d got=%0d want=%0d", i, rs_lat[br+i], LAT_EN ? st_delay[bs+i] : 0); end
      end
      for (int i = 0; i < 2; i++) begin
        total++; if (st_cyc[bs+i+1] - rs_cyc[br+i] !== GAP + 2)
          begin bad++; $display("FAIL b2b_gap%0d got=%0d want=%0d cycles accept-to-start", i, st_cyc[bs+i+1] - rs_cyc[br+i], GAP + 2); end
      end
    end
    tick(GAP + 4);
  endtask

  task automatic test_overflow();
    logic [31:0] a[6], s[6], r[6];
    logic rdy[6];
    int bs, br;
    bit ok;
    bs = n_starts; br = n_res;
    for (int i = 0; i < 6; i++) begin
      a[i] = $urandom; r[i] = $urandom; s[i] = 32'($urandom_range(900, 1)) + 32'(i * 1000);
    end
    fixed_delay = 100;
    push(a[0], s[0], r[0], rdy[0]);
    tick(3);
    for (int i = 1; i < 6; i++) push(a[i], s[i], r[i], rdy[i]);
    fixed_delay = 0;
    for (int i = 0; i < 5; i++) begin
      total++; if (rdy[i] !== 1'b1) begin bad++; $display("FAIL ovf_ready%0d got=%0h want=1", i, rdy[i]); end
    end
    total++; if (rdy[5] !== 1'b0) begin bad++; $display("FAIL ovf_ready_full got=%0h want=0", rdy[5]); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL ovf_busy got=%0h want=1", busy); end
    wait_res(br + 5, 1200, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL ovf_timeout got=%0d want=5 results", n_res - br); end
    tick(GAP + 40);
    total++; if (n_res - br !== 5) begin bad++; $display("FAIL ovf_result_count got=%0d want=5", n_res - br); end
    total++; if (n_starts - bs !== 5) begin bad++; $display("FAIL ovf_start_count got=%0d want=5", n_starts - bs); end
    if (ok) begin
      for (int i = 0; i < 5; i++) begin
        total++; if (rs_size[br+i] !== (s[i] << 1)) begin bad++; $display("FAIL ovf_size%0d got=%0d want=%0d", i, rs_size[br+i], s[i] << 1); end
      end
    end
  endtask

  task automatic test_zero_size();
    logic [31:0] a;
    int bs, br;
    bit ok;
    logic rdy;
    bs = n_starts; br = n_res;
    a = $urandom;
    push(a, 32'd0, 32'h1234, rdy);
    wait_res(br + 1, 50, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL zero_timeout got=%0d want=1 result", n_res - br); end
    total++; if (n_starts !== bs) begin bad++; $display("FAIL zero_no_start got=%0d want=0 starts", n_starts - bs); end
    if (ok) begin
      total++; if (rs_size[br] !== 32'd0) begin bad++; $display("FAIL zero_size got=%0d want=0", rs_size[br]); end
      total++; if (rs_lat[br] !== 32'd0) begin bad++; $display("FAIL zero_latency got=%0d want=0", rs_lat[br]); end
      total++; if (rs_maddr[br] !== a) begin bad++; $display("FAIL zero_addr got=%0h want=%0h", rs_maddr[br], a); end
    end
    tick(GAP + 4);
  endtask

  task automatic test_post_hold();
    logic [31:0] s1, s2;
    int bs, br, k;
    bit ok;
    logic rdy;
    bs = n_starts; br = n_res;
    s1 = 32'($urandom_range(3000, 1)); s2 = 32'($urandom_range(3000, 1));
    res_ready = 1'b0;
    push($urandom, s1, $urandom, rdy);
    push($urandom, s2, $urandom, rdy);
    k = 0;
    while (res_valid !== 1'b1 && k < 100) begin tick(1); k++; end
    total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL hold_timeout got=%0h want=1", res_valid); end
    for (int i = 0; i < 20; i++) begin
      tick(1);
      total++; if (res_valid !== 1'b1 || res_size !== (s1 << 1))
        begin bad++; $display("FAIL hold_stable%0d got=%0h/%0d want=1/%0d", i, res_valid, res_size, s1 << 1); end
      total++; if (n_starts - bs !== 1) begin bad++; $display("FAIL hold_no_start%0d got=%0d want=1", i, n_starts - bs); end
    end
    res_ready = 1'b1;
    wait_res(br + 2, 200, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL hold_release got=%0d want=2 results", n_res - br); end
    if (ok) begin
      total++; if (rs_size[br] !== (s1 << 1) || rs_size[br+1] !== (s2 << 1))
        begin bad++; $display("FAIL hold_order got=%0d,%0d want=%0d,%0d", rs_size[br], rs_size[br+1], s1 << 1, s2 << 1); end
      total++; if (st_cyc[bs+1] - rs_cyc[br] !== GAP + 2)
        begin bad++; $display("FAIL hold_gap got=%0d want=%0d", st_cyc[bs+1] - rs_cyc[br], GAP + 2); end
    end
    tick(GAP + 4);
  endtask

  task automatic test_reset_in_run();
    int bs, br, k;
    logic rdy;
    bs = n_starts; br = n_res;
    fixed_delay = 60;
    push($urandom, 32'd77, $urandom, rdy);
    k = 0;
    while (n_starts == bs && k < 20) begin tick(1); k++; end
    fixed_delay = 0;
    tick(5);
    nreset = 1'b0;
    tick(1);
    total++; if (rle_start !== 1'b0) begin bad++; $display("FAIL rst_run_start got=%0h want=0", rle_start); end
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL rst_run_valid got=%0h want=0", res_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_run_busy got=%0h want=0", busy); end
    total++; if (desc_ready !== 1'b1) begin bad++; $display("FAIL rst_run_ready got=%0h want=1", desc_ready); end
    total++; if (rle_message_size !== 32'd0) begin bad++; $display("FAIL rst_run_msg_size got=%0h want=0", rle_message_size); end
    nreset = 1'b1;
    force_done = 1'b1;
    tick(10);
    total++; if (res_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rst_stale_done got=%0h/%0h want=0/0", res_valid, busy); end
    total++; if (n_res !== br || n_starts - bs !== 1) begin bad++; $display("FAIL rst_stale_events got=%0d/%0d want=0/1", n_res - br, n_starts - bs); end
    force_done = 1'b0;
    tick(2);
  endtask

  task automatic test_random();
    logic [31:0] a[6], s[6], r[6];
    logic rdy;
    int bs, br, j;
    bit ok;
    bs = n_starts; br = n_res; j = 0;
    for (int i = 0; i < 6; i++) begin
      a[i] = $urandom; r[i] = $urandom;
      s[i] = ($urandom_range(3, 0) == 0) ? 32'd0 : 32'($urandom_range(60000, 1));
      push(a[i], s[i], r[i], rdy);
      total++; if (rdy !== 1'b1) begin bad++; $display("FAIL rnd_ready%0d got=%0h want=1", i, rdy); end
      wait_res(br + i + 1, 100, ok);
      total++; if (ok !== 1'b1) begin bad++; $display("FAIL rnd_timeout%0d got=%0d want=%0d", i, n_res - br, i + 1); end
      if (ok) begin
        total++; if (rs_size[br+i] !== (s[i] << 1)) begin bad++; $display("FAIL rnd_size%0d got=%0d want=%0d", i, rs_size[br+i], s[i] << 1); end
        if (s[i] != 0) begin
          total++; if (st_maddr[bs+j] !== a[i] || st_raddr[bs+j] !== r[i] || st_len[bs+j] !== 2)
            begin bad++; $display("FAIL rnd_start%0d got=%0h/%0h/%0d want=%0h/%0h/2", i, st_maddr[bs+j], st_raddr[bs+j], st_len[bs+j], a[i], r[i]); end
          total++; if (rs_lat[br+i] !== (LAT_EN ? 32'(st_delay[bs+j]) : 32'd0))
            begin bad++; $display("FAIL rnd_latency%0d got=%0d want=%0d", i, rs_lat[br+i], LAT_EN ? st_delay[bs+j] : 0); end
          j++;
        end else begin
          total++; if (rs_lat[br+i] !== 32'd0) begin bad++; $display("FAIL rnd_zero_latency%0d got=%0d want=0", i, rs_lat[br+i]); end
        end
      end
      tick(GAP + 4);
    end
    total++; if (n_starts - bs !== j) begin bad++; $display("FAIL rnd_start_count got=%0d want=%0d", n_starts - bs, j); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_zero_size();
    test_post_hold();
    test_reset_in_run();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
